press_event_detect: RTL and testbench

- Upstream neighbour of the pulse-expander stage in the pressure-sensing chain.
- Takes the stream of sampled sensor values and applies a threshold with hysteresis and a debounce count.
- Emits a single-cycle event_pulse on each qualified press onset; event_pulse feeds the expander's single-bit trigger input directly.
- Also provides a level output (active) showing that a press is in progress, and enforces a refractory gap between events.

---
 rtl/press_event_detect_if.sv | 24 ++
 rtl/press_event_detect.sv | 135 +++++++++++++
 tb/tb_press_event_detect.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/press_event_detect_if.sv
// press_event_detect_if: sample stream in, press events out.
//   master : drives sample_valid/sample_data, observes event_pulse/active/event_count
//   slave  : the detector side (inverse directions)
interface press_event_detect_if #(
    parameter int unsigned DATA_W = 12
);
    localparam int unsigned EVT_W = 16;

    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              event_pulse;
    logic              active;
    logic [EVT_W-1:0]  event_count;

    modport master (
        output sample_valid, sample_data,
        input  event_pulse, active, event_count
    );

    modport slave (
        input  sample_valid, sample_data,
        output event_pulse, active, event_count
    );
endinterface

// File: rtl/press_event_detect.sv
// press_event_detect: threshold-with-hysteresis press detector with debounce
// and a refractory gap. Emits a one-cycle event_pulse on each qualified press
// onset and holds active high while the press lasts.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : press_event_detect_if.slave (sample_valid, sample_data in;
//           event_pulse, active, event_count out)
// Optional build macro PRESS_EVENT_COUNT_EN adds a 16-bit wrapping event
// counter on event_count; otherwise event_count is tied to 0.
module press_event_detect #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned TH_HIGH  = 2000,
    parameter int unsigned TH_LOW   = 1800,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned REFRACT  = 16,
    parameter int unsigned REF_W    = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    press_event_detect_if.slave   bus
);
    localparam int unsigned EVT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        PRESS = 2'd2,
        REFR  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc_c;
    logic [REF_W-1:0]   ref_q, ref_d;
    logic               pulse_q, pulse_d;
    logic               active_q, active_d;
    logic               hi_c, lo_c;

    // Qualify / release decisions; only valid samples count.
    assign hi_c      = bus.sample_valid && (bus.sample_data >= DATA_W'(TH_HIGH));
    assign lo_c      = bus.sample_valid && (bus.sample_data <  DATA_W'(TH_LOW));
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ref_q    <= '0;
            pulse_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ref_q    <= ref_d;
            pulse_q  <= pulse_d;
            active_q <= active_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        case (state_q)
            IDLE: begin
                if (hi_c) begin
                    cnt_d   = CNT_W'(1);
                    state_d = (DEBOUNCE == 1) ? PRESS : ARM;
                end
            end
            ARM: begin
                if (hi_c) begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == CNT_W'(DEBOUNCE)) begin
                        state_d = PRESS;
                    end
                end else if (bus.sample_valid) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            PRESS: begin
                if (lo_c) begin
                    ref_d   = REF_W'(REFRACT);
                    state_d = REFR;
                end
            end
            REFR: begin
                // Counts every clock regardless of sample_valid; samples ignored.
                ref_d = ref_q - REF_W'(1);
                if (ref_q == REF_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ref_d   = '0;
            end
        endcase
    end

    // Output decode: pulse only on the edge that enters PRESS.
    always_comb begin
        pulse_d  = 1'b0;
        active_d = 1'b0;
        if (state_d == PRESS) begin
            active_d = 1'b1;
            pulse_d  = (state_q != PRESS);
        end
    end

    assign bus.event_pulse = pulse_q;
    assign bus.active      = active_q;

`ifdef PRESS_EVENT_COUNT_EN
    logic [EVT_W-1:0] evt_cnt_q;

    // Wrapping count of issued events.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            evt_cnt_q <= '0;
        end else if (pulse_d) begin
            evt_cnt_q <= evt_cnt_q + EVT_W'(1);
        end
    end

    assign bus.event_count = evt_cnt_q;
`else
    assign bus.event_count = EVT_W'(0);
`endif

endmodule

// File: tb/tb_press_event_detect.sv
// Testbench for press_event_detect: directed table, hand-written corner
// sequences and random stimulus checked against a behavioural model.
module tb_press_event_detect;
    localparam int unsigned DATA_W   = 12;
    localparam int          TH_HIGH  = 2000;
    localparam int          TH_LOW   = 1800;
    localparam int          DEBOUNCE = 4;
    localparam int          REFRACT  = 16;
    localparam int          NVEC     = 28;

    logic clock;
    logic reset;

    press_event_detect_if #(.DATA_W(DATA_W)) bus ();

    press_event_detect #(
        .DATA_W(DATA_W), .TH_HIGH(TH_HIGH), .TH_LOW(TH_LOW),
        .DEBOUNCE(DEBOUNCE), .CNT_W(3), .REFRACT(REFRACT), .REF_W(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors;
    int miscompares;

    // Behavioural model: run of consecutive qualifying samples, press flag,
    // remaining refractory cycles, event tally.
    int          m_run;
    bit          m_pressed;
    int          m_refr;
    bit          m_pulse;
    logic [15:0] m_events;

    typedef struct {
        logic v;
        int   d;
        logic p;
        logic a;
    } vec_t;

    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run     = 0;
        m_pressed = 0;
        m_refr    = 0;
        m_pulse   = 0;
        m_events  = 16'd0;
    endtask

    task automatic model_step(input logic v, input int d);
        m_pulse = 0;
        if (m_refr > 0) begin
            m_refr--;
        end else if (m_pressed) begin
            if (v && d < TH_LOW) begin
                m_pressed = 0;
                m_refr    = REFRACT;
            end
        end else if (v) begin
            if (d >= TH_HIGH) begin
                m_run++;
                if (m_run >= DEBOUNCE) begin
                    m_pressed = 1;
                    m_pulse   = 1;
                    m_run     = 0;
                    m_events  = m_events + 16'd1;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    function automatic logic [15:0] exp_count();
`ifdef PRESS_EVENT_COUNT_EN
        return m_events;
`else
        return 16'd0;
`endif
    endfunction

    // One clock: drive inputs, advance model at the edge, compare just after.
    task automatic cycle(input logic v, input int d);
        bus.sample_valid = v;
        bus.sample_data  = DATA_W'(d);
        @(posedge clock);
        model_step(v, d);
        #1;
        check("model_pulse",  16'(bus.event_pulse), 16'(m_pulse));
        check("model_active", 16'(bus.active),      16'(m_pressed));
        check("model_count",  bus.event_count,      exp_count());
    endtask

    // Reset pulsed between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        reset = 1'b1;
        #2;
        check("rst_pulse",  16'(bus.event_pulse), 16'd0);
        check("rst_active", 16'(bus.active),      16'd0);
        check("rst_count",  bus.event_count,      16'd0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        model_reset();

        // Press, hysteresis, release, refractory, then a fresh press.
        for (int i = 0; i < 4; i++) tbl[i] = '{v:1'b1, d:2100, p:(i == 3), a:(i == 3)};
        tbl[4] = '{v:1'b1, d:2100, p:1'b0, a:1'b1};
        tbl[5] = '{v:1'b1, d:1900, p:1'b0, a:1'b1};
        tbl[6] = '{v:1'b1, d:1800, p:1'b0, a:1'b1};
        tbl[7] = '{v:1'b1, d:1799, p:1'b0, a:1'b0};
        for (int i = 8;  i < 20; i++) tbl[i] = '{v:1'b0, d:0,    p:1'b0, a:1'b0};
        for (int i = 20; i < 24; i++) tbl[i] = '{v:1'b1, d:2100, p:1'b0, a:1'b0};
        for (int i = 24; i < 28; i++) tbl[i] = '{v:1'b1, d:2100, p:(i == 27), a:(i == 27)};

        repeat (3) @(posedge clock);
        check("reset_pulse",  16'(bus.event_pulse), 16'd0);
        check("reset_active", 16'(bus.active),      16'd0);
        check("reset_count",  bus.event_count,      16'd0);
        #1 reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            cycle(tbl[i].v, tbl[i].d);
            check($sformatf("tbl_pulse[%0d]", i),  16'(bus.event_pulse), 16'(tbl[i].p));
            check($sformatf("tbl_active[%0d]", i), 16'(bus.active),      16'(tbl[i].a));
        end

        // Aborted arm: 2100,2100,1500 then four 2100 -> one event on the last.
        async_reset();
        begin
            int seq [7] = '{2100, 2100, 1500, 2100, 2100, 2100, 2100};
            for (int i = 0; i < 7; i++) begin
                cycle(1'b1, seq[i]);
                check($sformatf("abort_pulse[%0d]", i), 16'(bus.event_pulse), 16'(i == 6));
            end
        end
        cycle(1'b1, 0);
        repeat (REFRACT) cycle(1'b0, 0);

        // Exact-threshold samples separated by invalid gaps.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, TH_HIGH);
            check($sformatf("gap_pulse[%0d]", k), 16'(bus.event_pulse), 16'(k == 3));
            repeat (3) begin
                cycle(1'b0, 0);
                check($sformatf("gap_active[%0d]", k), 16'(bus.active), 16'(k == 3));
            end
        end

        // Reset in the middle of PRESS clears outputs immediately.
        async_reset();
        // Three qualifying, reset, then a fresh four are required.
        repeat (3) cycle(1'b1, 2100);
        async_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2100);
            check($sformatf("post_rst_pulse[%0d]", i), 16'(bus.event_pulse), 16'(i == 3));
        end
        async_reset();

        // Three full press/release/refractory rounds.
        for (int r = 0; r < 3; r++) begin
            repeat (4) cycle(1'b1, 2100);
            cycle(1'b1, 100);
            repeat (REFRACT) cycle(1'b0, 0);
        end
`ifdef PRESS_EVENT_COUNT_EN
        check("event_count_3", bus.event_count, 16'd3);
`else
        check("event_count_0", bus.event_count, 16'd0);
`endif
        async_reset();

        // Random traffic concentrated around both thresholds.
        for (int n = 0; n < 3000; n++) begin
            logic v;
            int   d;
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       d = TH_HIGH - 2 + int'($urandom_range(0, 4));
                1:       d = TH_LOW  - 2 + int'($urandom_range(0, 4));
                2:       d = int'($urandom_range(0, 4095));
                default: d = 2100;
            endcase
            if ($urandom_range(0, 499) == 0) async_reset();
            cycle(v, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
